core_mem_responder: RTL and testbench

Responder for the core's instruction-fetch and data-memory ports. It holds a word-organised RAM that serves fetches and byte/half/word loads and stores. It also decodes an MMIO window containing a 64-bit machine timer, a buffered console transmitter and a `tohost` register. It sits outside `core` at the top level and is the bench's model of memory and peripherals.

---
 rtl/core_mem_responder_if.sv | 20 ++
 rtl/core_mem_responder.sv | 103 ++++++++++
 tb/tb_core_mem_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/core_mem_responder_if.sv
// core_mem_responder_if: fetch and data-memory bus between core and responder
interface core_mem_responder_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] icache_adr_i;
  logic [31:0]     icache_instr_o;
  logic            adr_v_i;
  logic [XLEN-1:0] adr_i;
  logic            is_store_i;
  logic [XLEN-1:0] store_data_i;
  logic [2:0]      access_size_i;
  logic [XLEN-1:0] load_data_o;
  logic            err_o;
  modport master (
    output icache_adr_i, adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
    input  icache_instr_o, load_data_o, err_o
  );
  modport slave (
    input  icache_adr_i, adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
    output icache_instr_o, load_data_o, err_o
  );
endinterface

// File: rtl/core_mem_responder.sv
// core_mem_responder: RAM plus MMIO timer, console FIFO and tohost for the core
module core_mem_responder #(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          TX_DIV    = 8
) (
  input  logic            clk,
  input  logic            reset,
  core_mem_responder_if.slave bus,
  output logic            timer_irq_o,
  output logic            console_v_o,
  output logic [7:0]      console_data_o,
  output logic            tohost_v_o,
  output logic [XLEN-1:0] tohost_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = TX_DIV > 1 ? $clog2(TX_DIV) : 1;
  logic [31:0] mem [DEPTH];
  logic [XLEN-1:0] ioff, roff, moff;
  logic ihit, rhit, mhit, b, h, w, err, ok, we, mw, full, empty, pop, push, accept, ovf;
  logic [2:0] sel, cnt;
  logic [4:0] sh;
  logic [3:0] be;
  logic [31:0] sd, wd, rword, mrd, ld;
  logic [63:0] mtime, mtimecmp;
  logic [7:0] fifo [4];
  logic [1:0] wp, rp;
  logic [DW-1:0] div;
  assign ioff = bus.icache_adr_i - XLEN'(RAM_BASE);
  assign roff = bus.adr_i - XLEN'(RAM_BASE);
  assign moff = bus.adr_i - XLEN'(MMIO_BASE);
  assign ihit = ioff < XLEN'(DEPTH * 4);
  assign rhit = roff < XLEN'(DEPTH * 4);
  assign mhit = moff < XLEN'(32);
  assign bus.icache_instr_o = ihit ? mem[ioff[AW+1:2]] : 32'h0000_0013;
  assign b = bus.access_size_i == 3'b001;
  assign h = bus.access_size_i == 3'b010;
  assign w = bus.access_size_i == 3'b100;
  assign err = bus.adr_v_i & (~(b | h | w) | (h & bus.adr_i[0]) | (w & |bus.adr_i[1:0])
             | ~(rhit | mhit) | (mhit & ~w));
  assign bus.err_o = err;
  assign ok = bus.adr_v_i & ~err;
  assign sh = {bus.adr_i[1:0], 3'b000};
  assign sd = bus.store_data_i[31:0];
  assign wd = sd << sh;
  assign be = (b ? 4'b0001 : h ? 4'b0011 : 4'b1111) << bus.adr_i[1:0];
  assign we = ok & bus.is_store_i & rhit;
  assign mw = ok & bus.is_store_i & mhit & ~rhit;
  assign sel = moff[4:2];
  assign rword = mem[roff[AW+1:2]];
  assign full = cnt[2];
  assign empty = cnt == 3'd0;
  always_comb begin
    mrd = sel == 3'd0 ? mtime[31:0] : sel == 3'd1 ? mtime[63:32] :
          sel == 3'd2 ? mtimecmp[31:0] : sel == 3'd3 ? mtimecmp[63:32] :
          sel == 3'd5 ? {29'd0, ovf, empty, full} : sel == 3'd6 ? tohost_o[31:0] : 32'd0;
    ld = ~ok ? 32'd0 : rhit ? (rword >> sh) & (b ? 32'hFF : h ? 32'hFFFF : 32'hFFFF_FFFF) : mrd;
  end
  assign bus.load_data_o = XLEN'(ld);
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[roff[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
  // a push while full survives only if the head leaves in the same cycle
  assign pop = (div == DW'(TX_DIV - 1)) & ~empty;
  assign push = mw & (sel == 3'd4);
  assign accept = push & (~full | pop);
  assign timer_irq_o = mtime >= mtimecmp;
  always_ff @(posedge clk)
    if (accept) fifo[wp] <= sd[7:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mtime <= '0;
      mtimecmp <= '1;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      div <= '0;
      ovf <= 1'b0;
      console_v_o <= 1'b0;
      console_data_o <= '0;
      tohost_v_o <= 1'b0;
      tohost_o <= '0;
    end else begin
      mtime <= (mw & sel == 3'd0) ? {mtime[63:32], sd} :
               (mw & sel == 3'd1) ? {sd, mtime[31:0]} : mtime + 64'd1;
      if (mw & sel == 3'd2) mtimecmp[31:0] <= sd;
      if (mw & sel == 3'd3) mtimecmp[63:32] <= sd;
      div <= (div == DW'(TX_DIV - 1)) ? '0 : div + 1'b1;
      if (accept) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + {2'b00, accept} - {2'b00, pop};
      if (push & ~accept) ovf <= 1'b1;
      console_v_o <= pop;
      if (pop) console_data_o <= fifo[rp];
      if (mw & sel == 3'd6) begin
        tohost_o <= bus.store_data_i;
        tohost_v_o <= 1'b1;
      end
    end
endmodule

// File: tb/tb_core_mem_responder.sv
// tb_core_mem_responder: directed checks of RAM, MMIO timer, console and tohost
module tb_core_mem_responder;
  localparam logic [31:0] MB = 32'h1000_0000;
  logic clk = 1'b0;
  logic reset;
  logic timer_irq_o, console_v_o, tohost_v_o;
  logic [7:0] console_data_o;
  logic [31:0] tohost_o;
  int checks = 0;
  int errors = 0;
  core_mem_responder_if #(.XLEN(32)) bus();
  core_mem_responder dut (
    .clk(clk), .reset(reset), .bus(bus), .timer_irq_o(timer_irq_o),
    .console_v_o(console_v_o), .console_data_o(console_data_o),
    .tohost_v_o(tohost_v_o), .tohost_o(tohost_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic acc(input logic st, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    bus.adr_v_i = 1'b1;
    bus.is_store_i = st;
    bus.adr_i = a;
    bus.store_data_i = d;
    bus.access_size_i = sz;
    #1;
  endtask
  task automatic idle();
    bus.adr_v_i = 1'b0;
    bus.is_store_i = 1'b0;
    #1;
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  task automatic rst();
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.icache_adr_i = '0;
    bus.adr_i = '0;
    bus.store_data_i = '0;
    bus.access_size_i = 3'b100;
    idle();
    dut.mem[4] = 32'hA1B2C3D4;
    dut.mem[16] = 32'h0;
    nxt();
    nxt();
    reset = 1'b0;
    #1;
    chk("rst_console_v", console_v_o, 0);
    chk("rst_console_data", console_data_o, 0);
    chk("rst_tohost_v", tohost_v_o, 0);
    chk("rst_tohost", tohost_o, 0);
    chk("rst_irq", timer_irq_o, 0);
    acc(0, MB + 32'h14, 0, 3'b100);
    chk("rst_status", bus.load_data_o, 32'h2);
    nxt();
    acc(0, 32'h12, 0, 3'b001);
    chk("ld_byte", bus.load_data_o, 32'hB2);
    chk("ld_byte_err", bus.err_o, 0);
    nxt();
    acc(0, 32'h12, 0, 3'b010);
    chk("ld_half", bus.load_data_o, 32'hA1B2);
    acc(0, 32'h10, 0, 3'b100);
    chk("ld_word", bus.load_data_o, 32'hA1B2C3D4);
    nxt();
    bus.icache_adr_i = 32'h12;
    #1;
    chk("fetch", bus.icache_instr_o, 32'hA1B2C3D4);
    bus.icache_adr_i = 32'h8000_0000;
    #1;
    chk("fetch_oor", bus.icache_instr_o, 32'h13);
    nxt();
    acc(1, 32'h41, 32'hEE, 3'b001);
    nxt();
    acc(0, 32'h40, 0, 3'b100);
    chk("st_byte", bus.load_data_o, 32'h0000EE00);
    acc(1, 32'h41, 32'h1234, 3'b010);
    chk("st_half_mis_err", bus.err_o, 1);
    nxt();
    acc(0, 32'h40, 0, 3'b100);
    chk("st_half_mis_kept", bus.load_data_o, 32'h0000EE00);
    chk("ld_word_err", bus.err_o, 0);
    nxt();
    acc(0, 32'h2000_0000, 0, 3'b100);
    chk("unmapped_err", bus.err_o, 1);
    acc(0, 32'h40, 0, 3'b011);
    chk("bad_size_err", bus.err_o, 1);
    chk("bad_size_ld", bus.load_data_o, 0);
    nxt();
    acc(0, MB, 0, 3'b001);
    chk("mmio_byte_err", bus.err_o, 1);
    acc(0, MB + 32'h10, 0, 3'b100);
    chk("tx_data_reads0", bus.load_data_o, 0);
    idle();
    chk("idle_err", bus.err_o, 0);
    rst();
    acc(1, MB + 32'h08, 32'd20, 3'b100);
    nxt();
    acc(1, MB + 32'h0C, 32'd0, 3'b100);
    nxt();
    idle();
    chk("irq_before", timer_irq_o, 0);
    acc(0, MB, 0, 3'b100);
    chk("mtime_lo_rd", bus.load_data_o, 32'd2);
    idle();
    repeat (17) nxt();
    chk("irq_at19", timer_irq_o, 0);
    nxt();
    chk("irq_at20", timer_irq_o, 1);
    acc(1, MB, 32'd0, 3'b100);
    nxt();
    idle();
    chk("irq_drop", timer_irq_o, 0);
    acc(0, MB, 0, 3'b100);
    chk("mtime_lo_clr", bus.load_data_o, 32'd0);
    acc(0, MB + 32'h04, 0, 3'b100);
    chk("mtime_hi", bus.load_data_o, 32'd0);
    rst();
    acc(1, MB + 32'h10, 32'h41, 3'b100);
    nxt();
    acc(1, MB + 32'h10, 32'h42, 3'b100);
    nxt();
    acc(1, MB + 32'h10, 32'h43, 3'b100);
    nxt();
    idle();
    repeat (4) nxt();
    chk("con_v_7", console_v_o, 0);
    nxt();
    chk("con_v_8", console_v_o, 1);
    chk("con_d_8", console_data_o, 8'h41);
    nxt();
    chk("con_v_9", console_v_o, 0);
    repeat (7) nxt();
    chk("con_v_16", console_v_o, 1);
    chk("con_d_16", console_data_o, 8'h42);
    repeat (8) nxt();
    chk("con_v_24", console_v_o, 1);
    chk("con_d_24", console_data_o, 8'h43);
    nxt();
    acc(0, MB + 32'h14, 0, 3'b100);
    chk("con_drained", bus.load_data_o, 32'h2);
    rst();
    for (int i = 0; i < 6; i++) begin
      acc(1, MB + 32'h10, 32'h51 + i, 3'b100);
      nxt();
    end
    acc(0, MB + 32'h14, 0, 3'b100);
    chk("ovf_status", bus.load_data_o, 32'h5);
    nxt();
    acc(1, MB + 32'h18, 32'd1, 3'b100);
    nxt();
    idle();
    chk("tohost_v", tohost_v_o, 1);
    chk("tohost", tohost_o, 1);
    chk("drain_v", console_v_o, 1);
    chk("drain_d", console_data_o, 8'h51);
    acc(0, MB + 32'h14, 0, 3'b100);
    chk("ovf_sticky", bus.load_data_o, 32'h4);
    acc(0, MB + 32'h18, 0, 3'b100);
    chk("tohost_rd", bus.load_data_o, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_tohost_v", tohost_v_o, 0);
    chk("mid_rst_tohost", tohost_o, 0);
    chk("mid_rst_con_v", console_v_o, 0);
    chk("mid_rst_con_d", console_data_o, 0);
    nxt();
    reset = 1'b0;
    acc(0, 32'h40, 0, 3'b100);
    chk("ram_kept", bus.load_data_o, 32'h0000EE00);
    acc(0, MB + 32'h14, 0, 3'b100);
    chk("post_rst_status", bus.load_data_o, 32'h2);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
